// File: rtl/multicycle_control_unit_pkg.sv
// riscv_ctrl_pkg: opcode, funct, state and instruction-class encodings shared by the control unit
package riscv_ctrl_pkg;
   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_SD = 7'b0100011;
   localparam logic [6:0] OP_BR = 7'b1100011;
   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_D   = 3'b011;
   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [6:0] F7_ADD = 7'b0000000;
   localparam logic [6:0] F7_SUB = 7'b0100000;
   localparam logic [2:0] ST_INIT   = 3'd0;
   localparam logic [2:0] ST_FETCH  = 3'd1;
   localparam logic [2:0] ST_DECODE = 3'd2;
   localparam logic [2:0] ST_EXEC   = 3'd3;
   localparam logic [2:0] ST_MEM    = 3'd4;
   localparam logic [2:0] ST_WB     = 3'd5;
   localparam logic [2:0] ST_HALT   = 3'd6;
   localparam logic [2:0] CL_R_ADD = 3'd0;
   localparam logic [2:0] CL_R_SUB = 3'd1;
   localparam logic [2:0] CL_I     = 3'd2;
   localparam logic [2:0] CL_LD    = 3'd3;
   localparam logic [2:0] CL_SD    = 3'd4;
   localparam logic [2:0] CL_BEQ   = 3'd5;
   localparam logic [2:0] CL_ILL   = 3'd7;
endpackage

// File: rtl/multicycle_control_unit_main_decoder.sv
// main_decoder: maps opcode/funct3/funct7 onto an instruction class
module main_decoder
   import riscv_ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   output logic [2:0] cls
);
   // first matching legal pattern wins; everything else is illegal
   always_comb begin
      cls = (opcode == OP_R  && funct3 == F3_ADD && funct7 == F7_ADD) ? CL_R_ADD :
            (opcode == OP_R  && funct3 == F3_ADD && funct7 == F7_SUB) ? CL_R_SUB :
            (opcode == OP_I  && funct3 == F3_ADD)                     ? CL_I     :
            (opcode == OP_LD && funct3 == F3_D)                       ? CL_LD    :
            (opcode == OP_SD && funct3 == F3_D)                       ? CL_SD    :
            (opcode == OP_BR && funct3 == F3_BEQ)                     ? CL_BEQ   : CL_ILL;
   end
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FETCH/DECODE/EXEC/MEM/WB sequencer producing datapath controls
module multicycle_control_unit
   import riscv_ctrl_pkg::*;
#(
   parameter logic HALT_ON_ILLEGAL = 1'b1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   input  logic       zero,
   output logic       ir_load,
   output logic       sub,
   output logic       WE_RF,
   output logic       WE_MEM,
   output logic       RF_din_sel,
   output logic       ULA_din2_sel,
   output logic       load_pc,
   output logic       pc_next_sel,
   output logic       reset_pc,
   output logic       halted,
   output logic [2:0] state_dbg
);
   logic [2:0] state_q, state_d, cls_q, cls_d, dec_cls;
   logic       is_ld, is_sd, is_beq, is_sub, imm_op, dec_ill;
   logic       in_dec, in_exec, in_mem, in_wb;

   main_decoder u_dec (
      .opcode (opcode),
      .funct3 (funct3),
      .funct7 (funct7),
      .cls    (dec_cls)
   );

   // class and state qualifiers; only the latched class steers post-decode outputs
   always_comb begin
      is_ld   = cls_q == CL_LD;
      is_sd   = cls_q == CL_SD;
      is_beq  = cls_q == CL_BEQ;
      is_sub  = cls_q == CL_R_SUB;
      imm_op  = cls_q == CL_I || is_ld || is_sd;
      dec_ill = dec_cls == CL_ILL;
      in_dec  = state_q == ST_DECODE;
      in_exec = state_q == ST_EXEC;
      in_mem  = state_q == ST_MEM;
      in_wb   = state_q == ST_WB;
   end

   // next-state and class latch; reset overrides everything
   always_comb begin
      state_d = state_q;
      cls_d   = cls_q;
      case (state_q)
         ST_INIT:   state_d = ST_FETCH;
         ST_FETCH:  state_d = ST_DECODE;
         ST_DECODE: begin
            cls_d   = dec_cls;
            state_d = !dec_ill ? ST_EXEC : HALT_ON_ILLEGAL ? ST_HALT : ST_FETCH;
         end
         ST_EXEC:   state_d = is_beq ? ST_FETCH : (is_ld || is_sd) ? ST_MEM : ST_WB;
         ST_MEM:    state_d = is_ld ? ST_WB : ST_FETCH;
         ST_WB:     state_d = ST_FETCH;
         ST_HALT:   state_d = ST_HALT;
         default:   state_d = ST_INIT;
      endcase
      if (RST) begin
         state_d = ST_INIT;
         cls_d   = CL_R_ADD;
      end
   end

   // state registers
   always_ff @(posedge CLK) begin
      state_q <= state_d;
      cls_q   <= cls_d;
   end

   // datapath controls; enables that change architectural state are masked while RST is high
   always_comb begin
      ir_load      = !RST && state_q == ST_FETCH;
      sub          = (is_sub && (in_exec || in_wb)) || (is_beq && in_exec);
      WE_RF        = !RST && in_wb;
      WE_MEM       = !RST && in_mem && is_sd;
      RF_din_sel   = in_wb && is_ld;
      ULA_din2_sel = imm_op && (in_exec || in_mem || in_wb);
      load_pc      = !RST && ((in_dec && dec_ill && !HALT_ON_ILLEGAL) || in_wb ||
                              (in_mem && is_sd) || (in_exec && is_beq));
      pc_next_sel  = in_exec && is_beq && zero;
      reset_pc     = state_q == ST_INIT;
      halted       = state_q == ST_HALT;
      state_dbg    = state_q;
   end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: random and directed checks of both illegal-handling variants against a per-class timeline model
module tb_multicycle_control_unit;
   localparam int C_ADD = 0, C_SUB = 1, C_ADDI = 2, C_LD = 3, C_SD = 4, C_BEQ = 5, C_ILL = 6;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        zero = 1'b0;
   logic [31:0] ins = 32'h0;
   logic        ir_l[2], sb[2], werf[2], wemem[2], rfsel[2], din2[2], ldpc[2], pcn[2], rpc[2], hlt[2];
   logic [2:0]  st[2];
   logic [9:0]  v[2];
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   // instance 0 halts on illegal instructions, instance 1 retires them as NOPs
   for (genvar g = 0; g < 2; g++) begin : g_dut
      multicycle_control_unit #(.HALT_ON_ILLEGAL(g == 0)) u_dut (
         .CLK          (clk),
         .RST          (rst),
         .opcode       (ins[6:0]),
         .funct3       (ins[14:12]),
         .funct7       (ins[31:25]),
         .zero         (zero),
         .ir_load      (ir_l[g]),
         .sub          (sb[g]),
         .WE_RF        (werf[g]),
         .WE_MEM       (wemem[g]),
         .RF_din_sel   (rfsel[g]),
         .ULA_din2_sel (din2[g]),
         .load_pc      (ldpc[g]),
         .pc_next_sel  (pcn[g]),
         .reset_pc     (rpc[g]),
         .halted       (hlt[g]),
         .state_dbg    (st[g])
      );
      assign v[g] = {ir_l[g], sb[g], werf[g], wemem[g], rfsel[g], din2[g], ldpc[g], pcn[g], rpc[g], hlt[g]};
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int classify(input logic [31:0] w);
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      op = w[6:0];
      f3 = w[14:12];
      f7 = w[31:25];
      if (op == 7'h33 && f3 == 3'd0 && f7 == 7'h00) return C_ADD;
      if (op == 7'h33 && f3 == 3'd0 && f7 == 7'h20) return C_SUB;
      if (op == 7'h13 && f3 == 3'd0) return C_ADDI;
      if (op == 7'h03 && f3 == 3'd3) return C_LD;
      if (op == 7'h23 && f3 == 3'd3) return C_SD;
      if (op == 7'h63 && f3 == 3'd0) return C_BEQ;
      return C_ILL;
   endfunction

   function automatic int seq_len(input int c);
      return c == C_LD ? 5 : c == C_BEQ ? 3 : c == C_ILL ? 2 : 4;
   endfunction

   // expected {ir_load,sub,WE_RF,WE_MEM,RF_din_sel,ULA_din2_sel,load_pc,pc_next_sel,reset_pc,halted} at cycle k of an instruction
   function automatic logic [9:0] exp_vec(input int c, input int k, input logic z, input logic nop);
      logic last, e_ir, e_sub, e_wrf, e_wm, e_rs, e_d2, e_lp, e_pn;
      last  = k == seq_len(c) - 1;
      e_ir  = k == 0;
      e_sub = (c == C_SUB && k >= 2) || (c == C_BEQ && k == 2);
      e_wrf = last && c <= C_LD;
      e_wm  = c == C_SD && k == 3;
      e_rs  = c == C_LD && k == 4;
      e_d2  = (c == C_ADDI || c == C_LD || c == C_SD) && k >= 2;
      e_lp  = last && (c != C_ILL || nop);
      e_pn  = c == C_BEQ && k == 2 && z;
      return {e_ir, e_sub, e_wrf, e_wm, e_rs, e_d2, e_lp, e_pn, 1'b0, 1'b0};
   endfunction

   function automatic logic [2:0] exp_state(input int c, input int k);
      if (k < 3) return 3'(k + 1);
      return (k == seq_len(c) - 1 && c <= C_LD) ? 3'd5 : 3'd4;
   endfunction

   // one clock of an instruction: sample on the falling edge, then step to just after the next rising edge
   task automatic step_check(input int c, input int k, input logic z, input logic h0);
      zero = z;
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         if (g == 0 && h0) begin
            chk("halt_vec", v[g], 10'b1);
            chk("halt_state", st[g], 3'd6);
         end else begin
            chk($sformatf("vec%0d_c%0d_k%0d", g, c, k), v[g], exp_vec(c, k, z, g == 1));
            chk($sformatf("state%0d_c%0d_k%0d", g, c, k), st[g], exp_state(c, k));
         end
         chk("inv_we_both", werf[g] & wemem[g], 0);
         chk("inv_ir_pc", ir_l[g] & ldpc[g], 0);
      end
      @(posedge clk);
      #1;
   endtask

   // zmode: 0/1 force zero, 2 randomizes it every cycle
   task automatic run_instr(input logic [31:0] w, input int zmode, input logic h0);
      int c;
      ins = w;
      c = classify(w);
      for (int k = 0; k < seq_len(c); k++)
         step_check(c, k, zmode == 2 ? 1'($urandom_range(0, 1)) : 1'(zmode), h0);
   endtask

   function automatic logic [31:0] gen_legal();
      logic [31:0] w;
      int          r;
      w = $urandom;
      r = $urandom_range(0, 5);
      w[6:0]   = r == 0 ? 7'h33 : r == 1 ? 7'h13 : r == 2 ? 7'h03 : r == 3 ? 7'h23 : r == 4 ? 7'h63 : 7'h33;
      w[14:12] = (r == 2 || r == 3) ? 3'd3 : 3'd0;
      if (r == 0 || r == 5) w[31:25] = r == 5 ? 7'h20 : 7'h00;
      return w;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      zero = 1'b0;
      repeat (2) begin
         @(negedge clk);
         for (int g = 0; g < 2; g++) chk("rst_gated", {ir_l[g], werf[g], wemem[g], ldpc[g]}, 4'b0);
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         chk("init_vec", v[g], 10'b10);
         chk("init_state", st[g], 3'd0);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      do_reset();
      run_instr(32'h002081B3, 2, 1'b0);
      run_instr(32'h402081B3, 2, 1'b0);
      run_instr(32'h0080B183, 2, 1'b0);
      run_instr(32'h0030B423, 2, 1'b0);
      run_instr(32'h00208463, 1, 1'b0);
      run_instr(32'h00208463, 0, 1'b0);
      for (int i = 0; i < 150; i++) run_instr(gen_legal(), 2, 1'b0);
      run_instr(32'h0000007F, 2, 1'b0);
      for (int i = 0; i < 3; i++) run_instr(gen_legal(), 2, 1'b1);
      for (int i = 0; i < 3; i++) run_instr($urandom, 2, 1'b1);
      do_reset();
      ins = 32'h0080B183;
      for (int k = 0; k < 3; k++) step_check(C_LD, k, 1'($urandom_range(0, 1)), 1'b0);
      rst = 1'b1;
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         chk("abort_we", {werf[g], wemem[g], ldpc[g], ir_l[g]}, 4'b0);
         chk("abort_state", st[g], 3'd4);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         chk("abort_init_vec", v[g], 10'b10);
         chk("abort_init_state", st[g], 3'd0);
      end
      @(posedge clk);
      #1;
      run_instr(32'h002081B3, 2, 1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
